// File: rtl/scgra_pkg.sv
// Shared CGRA PE definitions: opcodes, instruction field layout, ALU latency, sequencer states.
// No logic; imported by the issue sequencer and its sub-blocks.
package scgra_pkg;

  localparam int OPC_W       = 4;
  localparam int ALU_LAT_DEF = 4;

  localparam logic [OPC_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OPC_W-1:0] OP_MULADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADDADD = 4'h2;

  // Instruction word {Opcode, Dst, Src0, Src1, Src2}: field index in units of AW, LSB first.
  localparam int FLD_SRC2 = 0;
  localparam int FLD_SRC1 = 1;
  localparam int FLD_SRC0 = 2;
  localparam int FLD_DST  = 3;
  localparam int FLD_OPC  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/wb_delay_line.sv
// Write-back tag shift register: DEPTH cycles from in_* to out_*, one entry per cycle.
// No backpressure; empty_nxt means nothing will be presented on out_* after this cycle.
module wb_delay_line #(
  parameter int DEPTH = 4,
  parameter int PW    = 9
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          in_vld,
  input  logic [PW-1:0] in_dat,
  output logic          out_vld,
  output logic [PW-1:0] out_dat,
  output logic          empty_nxt
);

  localparam logic [DEPTH-1:0] TAIL = DEPTH'(1) << (DEPTH-1);

  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    dat_q [DEPTH];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q    <= (vld_q << 1) | DEPTH'(in_vld);
      dat_q[0] <= in_dat;
      for (int i = 1; i < DEPTH; i++) dat_q[i] <= dat_q[i-1];
    end
  end

  assign out_vld   = vld_q[DEPTH-1];
  assign out_dat   = dat_q[DEPTH-1];
  // Only the output stage (if anything) is occupied and nothing is entering.
  assign empty_nxt = ~in_vld & ~|(vld_q & ~TAIL);

endmodule

// File: rtl/pe_issue_seq.sv
// PE instruction sequencer: fetch, operand read, ALU issue, write-back 2+ALU_LAT cycles after fetch.
// One instruction per cycle while running; no stalls and no backpressure.
module pe_issue_seq
  import scgra_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AW      = 8,
  parameter int IAW     = 8,
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [IAW:0]      Inst_Num,
  output logic              Busy,
  output logic              Done,
  output logic [IAW-1:0]    IM_Addr,
  input  logic [4+4*AW-1:0] IM_Data,
  output logic [AW-1:0]     DM_RdAddr0,
  output logic [AW-1:0]     DM_RdAddr1,
  output logic [AW-1:0]     DM_RdAddr2,
  input  logic [DWIDTH-1:0] DM_RdData0,
  input  logic [DWIDTH-1:0] DM_RdData1,
  input  logic [DWIDTH-1:0] DM_RdData2,
  output logic [DWIDTH-1:0] ALU_In0,
  output logic [DWIDTH-1:0] ALU_In1,
  output logic [DWIDTH-1:0] ALU_In2,
  output logic [3:0]        Opcode,
  input  logic [DWIDTH-1:0] ALU_Out,
  output logic              DM_WrEn,
  output logic [AW-1:0]     DM_WrAddr,
  output logic [DWIDTH-1:0] DM_WrData
);

  seq_state_t state;
  logic [IAW:0] pc;
  logic [IAW:0] num;

  logic          iss_vld_q1;
  logic          iss_vld_q2;
  logic [3:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] rd_hold0, rd_hold1, rd_hold2;

  logic          wb_vld;
  logic [AW:0]   wb_dat;
  logic          dl_empty_nxt;

  logic [3:0]    im_op;
  logic [AW-1:0] im_dst, im_src0, im_src1, im_src2;

  assign im_op   = IM_Data[FLD_OPC*AW  +: OPC_W];
  assign im_dst  = IM_Data[FLD_DST*AW  +: AW];
  assign im_src0 = IM_Data[FLD_SRC0*AW +: AW];
  assign im_src1 = IM_Data[FLD_SRC1*AW +: AW];
  assign im_src2 = IM_Data[FLD_SRC2*AW +: AW];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      pc    <= '0;
      num   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            num  <= Inst_Num;
            Busy <= 1'b1;
            if (Inst_Num == '0) begin
              state <= ST_DONE;
              Done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              pc    <= '0;
            end
          end
        end
        ST_RUN: begin
          // PC stops on the last fetch so it never wraps past 2^IAW-1.
          if (pc == num - (IAW+1)'(1)) state <= ST_DRAIN;
          else                         pc    <= pc + (IAW+1)'(1);
        end
        ST_DRAIN: begin
          if (!iss_vld_q1 && dl_empty_nxt) begin
            state <= ST_DONE;
            Done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      iss_vld_q1 <= 1'b0;
      iss_vld_q2 <= 1'b0;
      op_q       <= OP_NOP;
      dst_q      <= '0;
      rd_hold0   <= '0;
      rd_hold1   <= '0;
      rd_hold2   <= '0;
    end else begin
      iss_vld_q1 <= (state == ST_RUN);
      iss_vld_q2 <= iss_vld_q1;
      op_q       <= iss_vld_q1 ? im_op : OP_NOP;
      dst_q      <= iss_vld_q1 ? im_dst : dst_q;
      rd_hold0   <= DM_RdAddr0;
      rd_hold1   <= DM_RdAddr1;
      rd_hold2   <= DM_RdAddr2;
    end
  end

  assign IM_Addr    = pc[IAW-1:0];
  assign DM_RdAddr0 = iss_vld_q1 ? im_src0 : rd_hold0;
  assign DM_RdAddr1 = iss_vld_q1 ? im_src1 : rd_hold1;
  assign DM_RdAddr2 = iss_vld_q1 ? im_src2 : rd_hold2;

  assign ALU_In0 = DM_RdData0;
  assign ALU_In1 = DM_RdData1;
  assign ALU_In2 = DM_RdData2;
  assign Opcode  = op_q;

  // Every issued slot is tracked (NOPs included) so the drain length stays fixed.
  wb_delay_line #(
    .DEPTH (ALU_LAT),
    .PW    (AW+1)
  ) u_wb_dl (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_vld    (iss_vld_q2),
    .in_dat    ({op_q != OP_NOP, dst_q}),
    .out_vld   (wb_vld),
    .out_dat   (wb_dat),
    .empty_nxt (dl_empty_nxt)
  );

  assign DM_WrEn   = wb_vld & wb_dat[AW];
  assign DM_WrAddr = wb_dat[AW-1:0];
  assign DM_WrData = ALU_Out;

endmodule

// File: tb/tb_pe_issue_seq.sv
// Directed bench for pe_issue_seq with IM/DM models, a 4-stage ALU model and a write monitor.
module tb_pe_issue_seq;
  import scgra_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int IAW = 8;
  localparam int LAT = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Start = 1'b0;
  logic [IAW:0]      Inst_Num = '0;
  logic              Busy, Done;
  logic [IAW-1:0]    IM_Addr;
  logic [4+4*AW-1:0] IM_Data;
  logic [AW-1:0]     DM_RdAddr0, DM_RdAddr1, DM_RdAddr2;
  logic [DW-1:0]     DM_RdData0, DM_RdData1, DM_RdData2;
  logic [DW-1:0]     ALU_In0, ALU_In1, ALU_In2;
  logic [3:0]        Opcode;
  logic [DW-1:0]     ALU_Out;
  logic              DM_WrEn;
  logic [AW-1:0]     DM_WrAddr;
  logic [DW-1:0]     DM_WrData;

  always #5 Clk = ~Clk;

  pe_issue_seq #(.DWIDTH(DW), .AW(AW), .IAW(IAW), .ALU_LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Inst_Num(Inst_Num),
    .Busy(Busy), .Done(Done), .IM_Addr(IM_Addr), .IM_Data(IM_Data),
    .DM_RdAddr0(DM_RdAddr0), .DM_RdAddr1(DM_RdAddr1), .DM_RdAddr2(DM_RdAddr2),
    .DM_RdData0(DM_RdData0), .DM_RdData1(DM_RdData1), .DM_RdData2(DM_RdData2),
    .ALU_In0(ALU_In0), .ALU_In1(ALU_In1), .ALU_In2(ALU_In2),
    .Opcode(Opcode), .ALU_Out(ALU_Out),
    .DM_WrEn(DM_WrEn), .DM_WrAddr(DM_WrAddr), .DM_WrData(DM_WrData)
  );

  logic [4+4*AW-1:0] im [256];
  logic [DW-1:0]     dm [256];
  logic              tb_we = 1'b0;
  logic [AW-1:0]     tb_wa = '0;
  logic [DW-1:0]     tb_wd = '0;
  logic [DW-1:0]     alu_pipe [LAT];

  function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a, b, c);
    case (op)
      OP_MULADD: return a * b + c;
      OP_ADDADD: return a + b + c;
      default:   return '0;
    endcase
  endfunction

  function automatic logic [4+4*AW-1:0] inst(input logic [3:0] op, input int d, s0, s1, s2);
    return {op, d[AW-1:0], s0[AW-1:0], s1[AW-1:0], s2[AW-1:0]};
  endfunction

  // Synchronous memories; a same-cycle read of a written address returns old data.
  always @(posedge Clk) begin
    IM_Data    <= im[IM_Addr];
    DM_RdData0 <= dm[DM_RdAddr0];
    DM_RdData1 <= dm[DM_RdAddr1];
    DM_RdData2 <= dm[DM_RdAddr2];
    if (DM_WrEn)    dm[DM_WrAddr] <= DM_WrData;
    else if (tb_we) dm[tb_wa]     <= tb_wd;
    alu_pipe[0] <= alu_f(Opcode, ALU_In0, ALU_In1, ALU_In2);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign ALU_Out = alu_pipe[LAT-1];

  int            cyc = 0;
  int            busy_cnt = 0;
  int            wr_cyc [$];
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_dat [$];
  int            done_cyc [$];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (DM_WrEn) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(DM_WrAddr);
      wr_dat.push_back(DM_WrData);
    end
    if (Done) done_cyc.push_back(cyc);
    if (Busy) busy_cnt <= busy_cnt + 1;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic dm_wr(input int a, input logic [DW-1:0] d);
    tb_we = 1'b1;
    tb_wa = a[AW-1:0];
    tb_wd = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic start_run(input int n, output int s);
    tick();
    Start    = 1'b1;
    Inst_Num = n[IAW:0];
    s        = cyc;
    tick();
    Start    = 1'b0;
    Inst_Num = '0;
  endtask

  task automatic wait_done(input string tag, input int idx, input int budget);
    int k;
    k = 0;
    while (done_cyc.size() <= idx && k < budget) begin
      tick();
      k++;
    end
    chk(tag, done_cyc.size() > idx, 1);
  endtask

  task automatic chk_wr(input string tag, input int idx, input int c, input int a, input logic [DW-1:0] d);
    chk({tag, "_cyc"},  wr_cyc[idx], c);
    chk({tag, "_addr"}, wr_addr[idx], a);
    chk({tag, "_data"}, wr_dat[idx], d);
  endtask

  initial begin
    int s, w0, d0, b0, bad, nexp;
    logic [DW-1:0] sh [128];
    int e_cyc [$];
    int e_addr [$];
    logic [DW-1:0] e_dat [$];

    repeat (3) tick();
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_wren", DM_WrEn, 0);
    chk("rst_opcode", Opcode, 0);
    chk("rst_imaddr", IM_Addr, 0);
    chk("rst_rdaddr0", DM_RdAddr0, 0);
    chk("rst_rdaddr1", DM_RdAddr1, 0);
    chk("rst_rdaddr2", DM_RdAddr2, 0);
    Reset = 1'b0;

    dm_wr(1, 10); dm_wr(2, 20); dm_wr(3, 30); dm_wr(4, 3); dm_wr(6, 7);

    // Single ADDADD: 10+20+30 -> DM[5] at t+6, Done one cycle later.
    im[0] = inst(OP_ADDADD, 5, 1, 2, 3);
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    start_run(1, s);
    to_cycle(s + 2);
    chk("t1_rdaddr0", DM_RdAddr0, 1);
    chk("t1_rdaddr2", DM_RdAddr2, 3);
    to_cycle(s + 3);
    chk("t1_opcode", Opcode, OP_ADDADD);
    chk("t1_alu_in1", ALU_In1, 20);
    to_cycle(s + 4);
    chk("t1_opcode_idle", Opcode, OP_NOP);
    wait_done("t1_done_seen", d0, 40);
    repeat (3) tick();
    chk("t1_nwr", wr_cyc.size() - w0, 1);
    chk_wr("t1_wr", w0, s + 7, 5, 60);
    chk("t1_done_cyc", done_cyc[d0], s + 8);
    chk("t1_ndone", done_cyc.size() - d0, 1);

    // Four back-to-back issues with a NOP in slot 2.
    im[0] = inst(OP_MULADD, 8, 1, 2, 3);
    im[1] = inst(OP_ADDADD, 9, 4, 1, 6);
    im[2] = inst(OP_NOP, 10, 1, 1, 1);
    im[3] = inst(OP_ADDADD, 11, 5, 2, 3);
    w0 = wr_cyc.size(); d0 = done_cyc.size(); b0 = busy_cnt;
    start_run(4, s);
    wait_done("t2_done_seen", d0, 40);
    repeat (3) tick();
    chk("t2_nwr", wr_cyc.size() - w0, 3);
    chk_wr("t2_wr0", w0,     s + 7,  8,  230);
    chk_wr("t2_wr1", w0 + 1, s + 8,  9,  20);
    chk_wr("t2_wr3", w0 + 2, s + 10, 11, 110);
    chk("t2_done_cyc", done_cyc[d0], s + 11);
    chk("t2_busy_cycles", busy_cnt - b0, 11);

    // Empty run.
    w0 = wr_cyc.size(); d0 = done_cyc.size(); b0 = busy_cnt;
    start_run(0, s);
    repeat (4) tick();
    chk("t3_done_cyc", done_cyc[d0], s + 1);
    chk("t3_ndone", done_cyc.size() - d0, 1);
    chk("t3_nwr", wr_cyc.size() - w0, 0);
    chk("t3_busy_cycles", busy_cnt - b0, 1);
    chk("t3_rdaddr_hold", DM_RdAddr0, 5);

    // Start during RUN is ignored.
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    start_run(3, s);
    to_cycle(s + 2);
    Start = 1'b1; Inst_Num = 9;
    tick();
    Start = 1'b0; Inst_Num = '0;
    wait_done("t4_done_seen", d0, 40);
    repeat (12) tick();
    chk("t4_done_cyc", done_cyc[d0], s + 10);
    chk("t4_ndone", done_cyc.size() - d0, 1);
    chk("t4_nwr", wr_cyc.size() - w0, 2);
    chk_wr("t4_wr1", w0 + 1, s + 8, 9, 20);

    // Reset mid-run aborts everything.
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    start_run(4, s);
    to_cycle(s + 3);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t5_busy_after_rst", Busy, 0);
    chk("t5_wren_after_rst", DM_WrEn, 0);
    repeat (12) tick();
    chk("t5_nwr", wr_cyc.size() - w0, 0);
    chk("t5_ndone", done_cyc.size() - d0, 0);
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    start_run(1, s);
    wait_done("t5_done_seen", d0, 40);
    repeat (3) tick();
    chk("t5_nwr_fresh", wr_cyc.size() - w0, 1);
    chk_wr("t5_wr", w0, s + 7, 8, 230);
    chk("t5_done_cyc", done_cyc[d0], s + 8);

    // Full 256-instruction run; sources in 0..127, destinations in 128..255.
    for (int i = 0; i < 128; i++) begin
      sh[i] = $urandom;
      dm_wr(i, sh[i]);
    end
    for (int i = 0; i < 256; i++) begin
      logic [3:0] op;
      int d, a0, a1, a2;
      op = 4'($urandom_range(0, 2));
      d  = $urandom_range(128, 255);
      a0 = $urandom_range(0, 127);
      a1 = $urandom_range(0, 127);
      a2 = $urandom_range(0, 127);
      im[i] = inst(op, d, a0, a1, a2);
      if (op != OP_NOP) begin
        e_cyc.push_back(i + 7);
        e_addr.push_back(d);
        e_dat.push_back(alu_f(op, sh[a0], sh[a1], sh[a2]));
      end
    end
    nexp = e_cyc.size();
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    start_run(256, s);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      to_cycle(s + 1 + i);
      if (IM_Addr !== 8'(i)) bad++;
    end
    chk("t6_sweep_bad", bad, 0);
    wait_done("t6_done_seen", d0, 400);
    repeat (3) tick();
    chk("t6_nwr", wr_cyc.size() - w0, nexp);
    bad = 0;
    for (int k = 0; k < nexp; k++) begin
      if (w0 + k >= wr_cyc.size()) bad++;
      else if (wr_cyc[w0+k] != s + e_cyc[k] || wr_addr[w0+k] !== 8'(e_addr[k]) ||
               wr_dat[w0+k] !== e_dat[k]) bad++;
    end
    chk("t6_scoreboard_bad", bad, 0);
    chk("t6_done_cyc", done_cyc[d0], s + 263);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
